// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: ALU op encodings, register
// numbers and the ID/EX control bundle with its bubble value.
package mips_pkg;

  // ALU operation encodings, shared with the EX-stage ALU.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_SLT = 3'b011,
    ALU_OR  = 3'b100
  } alu_op_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width-independent control part of the ID/EX register.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
  } id_ex_ctrl_t;

  // A bubble is an ADD to r0 that never writes back; data fields are zeroed
  // separately by the stage.
  localparam id_ex_ctrl_t BUBBLE_CTRL = '{
    valid:     1'b0,
    pc:        32'h0,
    rs:        REG_ZERO,
    rt:        REG_ZERO,
    wa:        REG_ZERO,
    alu_op:    ALU_ADD,
    alu_src:   1'b0,
    reg_write: 1'b0
  };

endpackage

// File: rtl/fwd_mux.sv
// MEM/WB forwarding select for one source operand. MEM is the younger
// producer and therefore wins over WB; r0 is never forwarded.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [4:0]       reg_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic             mem_we_i,
  input  logic [4:0]       mem_wa_i,
  input  logic [WIDTH-1:0] mem_wd_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_wa_i,
  input  logic [WIDTH-1:0] wb_wd_i,
  output logic [WIDTH-1:0] val_o
);

  // Priority select: r0 guard, then MEM, then WB, else the latched value.
  always_comb begin
    val_o = val_i;
    if (reg_i == REG_ZERO) begin
      val_o = val_i;
    end else if (mem_we_i && (mem_wa_i == reg_i)) begin
      val_o = mem_wd_i;
    end else if (wb_we_i && (wb_wa_i == reg_i)) begin
      val_o = wb_wd_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding at its outputs,
// bubble insertion for stall/flush, hold for EX back-pressure and a
// saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_wa,
  input  logic [2:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [4:0]       mem_wa,
  input  logic [4:0]       wb_wa,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] wb_wd,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] ex_rt_val,
  output logic [4:0]       ex_wa,
  output logic             ex_reg_write,
  output logic [31:0]      ex_pc,
  output logic             ex_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  id_ex_ctrl_t      ctrl_q, ctrl_d;
  logic [WIDTH-1:0] rs_val_q, rs_val_d;
  logic [WIDTH-1:0] rt_val_q, rt_val_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic [WIDTH-1:0] rs_fwd, rt_fwd;

  fwd_mux #(
    .WIDTH (WIDTH)
  ) u_fwd_rs (
    .reg_i    (ctrl_q.rs),
    .val_i    (rs_val_q),
    .mem_we_i (mem_we),
    .mem_wa_i (mem_wa),
    .mem_wd_i (mem_wd),
    .wb_we_i  (wb_we),
    .wb_wa_i  (wb_wa),
    .wb_wd_i  (wb_wd),
    .val_o    (rs_fwd)
  );

  fwd_mux #(
    .WIDTH (WIDTH)
  ) u_fwd_rt (
    .reg_i    (ctrl_q.rt),
    .val_i    (rt_val_q),
    .mem_we_i (mem_we),
    .mem_wa_i (mem_wa),
    .mem_wd_i (mem_wd),
    .wb_we_i  (wb_we),
    .wb_wa_i  (wb_wa),
    .wb_wd_i  (wb_wd),
    .val_o    (rt_fwd)
  );

  // Next-state: hold beats bubble beats load. While held, operands are
  // refreshed with their forwarded values because the producer may retire
  // from WB before EX is released.
  always_comb begin
    ctrl_d       = ctrl_q;
    rs_val_d     = rs_val_q;
    rt_val_d     = rt_val_q;
    imm_d        = imm_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hold) begin
      rs_val_d = rs_fwd;
      rt_val_d = rt_fwd;
    end else if (flush || stall) begin
      ctrl_d   = BUBBLE_CTRL;
      rs_val_d = '0;
      rt_val_d = '0;
      imm_d    = '0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ctrl_d.valid     = id_valid;
      ctrl_d.pc        = id_pc;
      ctrl_d.rs        = id_rs;
      ctrl_d.rt        = id_rt;
      ctrl_d.wa        = id_wa;
      ctrl_d.alu_op    = alu_op_e'(id_alu_op);
      ctrl_d.alu_src   = id_alu_src;
      ctrl_d.reg_write = id_reg_write;
      rs_val_d         = id_rs_data;
      rt_val_d         = id_rt_data;
      imm_d            = id_imm;
    end
  end

  // Stage register; reset leaves a bubble and a cleared counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= BUBBLE_CTRL;
      rs_val_q     <= '0;
      rt_val_q     <= '0;
      imm_q        <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      rs_val_q     <= rs_val_d;
      rt_val_q     <= rt_val_d;
      imm_q        <= imm_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // ALU-facing outputs, combinational from registered state and MEM/WB.
  always_comb begin
    A            = rs_fwd;
    B            = ctrl_q.alu_src ? imm_q : rt_fwd;
    ALUOp        = ctrl_q.alu_op;
    ex_rt_val    = rt_fwd;
    ex_wa        = ctrl_q.wa;
    ex_reg_write = ctrl_q.reg_write & ctrl_q.valid;
    ex_pc        = ctrl_q.pc;
    ex_valid     = ctrl_q.valid;
    bubble_cnt   = bubble_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written hold/reset
// sequences, randomized traffic against a reference model, counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, hold, id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_reg_write;
  logic [4:0]  mem_wa, wb_wa;
  logic        mem_we, wb_we;
  logic [31:0] mem_wd, wb_wd;
  logic [31:0] A, B, ex_rt_val, ex_pc;
  logic [2:0]  ALUOp;
  logic [4:0]  ex_wa;
  logic        ex_reg_write, ex_valid;
  logic [15:0] bubble_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .WIDTH (32),
    .CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .hold         (hold),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_imm       (id_imm),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_wa        (id_wa),
    .id_alu_op    (id_alu_op),
    .id_alu_src   (id_alu_src),
    .id_reg_write (id_reg_write),
    .mem_wa       (mem_wa),
    .wb_wa        (wb_wa),
    .mem_we       (mem_we),
    .wb_we        (wb_we),
    .mem_wd       (mem_wd),
    .wb_wd        (wb_wd),
    .A            (A),
    .B            (B),
    .ALUOp        (ALUOp),
    .ex_rt_val    (ex_rt_val),
    .ex_wa        (ex_wa),
    .ex_reg_write (ex_reg_write),
    .ex_pc        (ex_pc),
    .ex_valid     (ex_valid),
    .bubble_cnt   (bubble_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs held across one edge, outputs checked after it.
  typedef struct {
    logic        stall, flush, iv;
    logic [31:0] pc, rs_d, rt_d, imm;
    logic [4:0]  rs, rt, wa;
    logic [2:0]  op;
    logic        src, rw;
    logic [4:0]  mwa;
    logic        mwe;
    logic [31:0] mwd;
    logic [4:0]  wwa;
    logic        wwe;
    logic [31:0] wwd;
    logic [31:0] ea, eb;
    logic [2:0]  eop;
    logic        ev, erw;
    logic [31:0] epc;
    logic [4:0]  ewa;
    logic [15:0] ecnt;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  // Reference model: the EX-stage contents as plain values.
  typedef struct {
    bit        valid;
    bit [31:0] pc, rs_val, rt_val, imm;
    bit [4:0]  rs, rt, wa;
    bit [2:0]  op;
    bit        src, rw;
  } mstate_t;

  mstate_t     m, nm;
  int unsigned mcnt, ncnt;

  function automatic logic [31:0] fwd_ref(input logic [4:0] r, input logic [31:0] v);
    if (r == 5'd0) return v;
    if (mem_we && mem_wa == r) return mem_wd;
    if (wb_we && wb_wa == r) return wb_wd;
    return v;
  endfunction

  task automatic model_next();
    ncnt = mcnt;
    if (hold) begin
      nm        = m;
      nm.rs_val = fwd_ref(m.rs, m.rs_val);
      nm.rt_val = fwd_ref(m.rt, m.rt_val);
    end else if (stall || flush) begin
      nm = '{default: 0};
      if (mcnt < 32'd65535) ncnt = mcnt + 1;
    end else begin
      nm = '{valid: id_valid, pc: id_pc, rs_val: id_rs_data, rt_val: id_rt_data,
             imm: id_imm, rs: id_rs, rt: id_rt, wa: id_wa, op: id_alu_op,
             src: id_alu_src, rw: id_reg_write};
    end
  endtask

  task automatic check_model();
    logic [31:0] rt_f;
    rt_f = fwd_ref(m.rt, m.rt_val);
    chk("rnd_A", A, fwd_ref(m.rs, m.rs_val));
    chk("rnd_B", B, m.src ? m.imm : rt_f);
    chk("rnd_ALUOp", 32'(ALUOp), 32'(m.op));
    chk("rnd_rt_val", ex_rt_val, rt_f);
    chk("rnd_wa", 32'(ex_wa), 32'(m.wa));
    chk("rnd_reg_write", 32'(ex_reg_write), 32'(m.rw & m.valid));
    chk("rnd_pc", ex_pc, m.pc);
    chk("rnd_valid", 32'(ex_valid), 32'(m.valid));
    chk("rnd_cnt", 32'(bubble_cnt), mcnt);
  endtask

  task automatic check_zero(input string nm_s);
    chk({nm_s, "_A"}, A, 32'h0);
    chk({nm_s, "_B"}, B, 32'h0);
    chk({nm_s, "_ALUOp"}, 32'(ALUOp), 32'h0);
    chk({nm_s, "_rt_val"}, ex_rt_val, 32'h0);
    chk({nm_s, "_wa"}, 32'(ex_wa), 32'h0);
    chk({nm_s, "_reg_write"}, 32'(ex_reg_write), 32'h0);
    chk({nm_s, "_pc"}, ex_pc, 32'h0);
    chk({nm_s, "_valid"}, 32'(ex_valid), 32'h0);
    chk({nm_s, "_cnt"}, 32'(bubble_cnt), 32'h0);
  endtask

  task automatic idle_fwd();
    mem_we = 1'b0; mem_wa = 5'd0; mem_wd = 32'h0;
    wb_we  = 1'b0; wb_wa  = 5'd0; wb_wd  = 32'h0;
  endtask

  initial begin
    //        stall flush iv    pc        rs_d      rt_d      imm       rs    rt    wa     op    src   rw
    //        mwa   mwe   mwd         wwa   wwe   wwd         ea        eb        eop   ev    erw
    //        epc       ewa    ecnt
    vt[0] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'h36, 32'h1D, 32'h0, 5'd1, 5'd2, 5'd3, 3'd4, 1'b0, 1'b1,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h36, 32'h1D, 3'd4, 1'b1, 1'b1,
              32'h100, 5'd3, 16'd0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 32'h104, 32'h11, 32'h22, 32'h0, 5'd5, 5'd6, 5'd4, 3'd1, 1'b0, 1'b1,
              5'd5, 1'b1, 32'hAAAA, 5'd5, 1'b1, 32'hBBBB, 32'hAAAA, 32'h22, 3'd1, 1'b1, 1'b1,
              32'h104, 5'd4, 16'd0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h104, 32'h11, 32'h22, 32'h0, 5'd5, 5'd6, 5'd4, 3'd1, 1'b0, 1'b1,
              5'd5, 1'b0, 32'hAAAA, 5'd5, 1'b1, 32'hBBBB, 32'hBBBB, 32'h22, 3'd1, 1'b1, 1'b1,
              32'h104, 5'd4, 16'd0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h108, 32'h77, 32'h0, 32'h0, 5'd7, 5'd0, 5'd10, 3'd2, 1'b0, 1'b0,
              5'd0, 1'b1, 32'hFFFF, 5'd0, 1'b0, 32'h0, 32'h77, 32'h0, 3'd2, 1'b1, 1'b0,
              32'h108, 5'd10, 16'd0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 32'h10C, 32'h5, 32'h6, 32'h7, 5'd3, 5'd4, 5'd5, 3'd3, 1'b0, 1'b1,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0,
              32'h0, 5'd0, 16'd1};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'h10C, 32'h5, 32'h6, 32'h7, 5'd3, 5'd4, 5'd5, 3'd3, 1'b0, 1'b1,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0,
              32'h0, 5'd0, 16'd2};
    vt[6] = '{1'b0, 1'b1, 1'b1, 32'h10C, 32'h5, 32'h6, 32'h7, 5'd3, 5'd4, 5'd5, 3'd3, 1'b0, 1'b1,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0,
              32'h0, 5'd0, 16'd3};
    vt[7] = '{1'b0, 1'b0, 1'b1, 32'h120, 32'h10, 32'h99, 32'h5A, 5'd1, 5'd2, 5'd9, 3'd3, 1'b1, 1'b1,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h10, 32'h5A, 3'd3, 1'b1, 1'b1,
              32'h120, 5'd9, 16'd3};
    vt[8] = '{1'b0, 1'b0, 1'b0, 32'h124, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd5, 3'd0, 1'b0, 1'b1,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h3, 32'h4, 3'd0, 1'b0, 1'b0,
              32'h124, 5'd5, 16'd3};

    // Reset state.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
    id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_wa = '0; id_alu_op = '0; id_alu_src = 1'b0; id_reg_write = 1'b0;
    idle_fwd();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      stall = vt[i].stall; flush = vt[i].flush; hold = 1'b0; id_valid = vt[i].iv;
      id_pc = vt[i].pc; id_rs_data = vt[i].rs_d; id_rt_data = vt[i].rt_d; id_imm = vt[i].imm;
      id_rs = vt[i].rs; id_rt = vt[i].rt; id_wa = vt[i].wa; id_alu_op = vt[i].op;
      id_alu_src = vt[i].src; id_reg_write = vt[i].rw;
      mem_wa = vt[i].mwa; mem_we = vt[i].mwe; mem_wd = vt[i].mwd;
      wb_wa = vt[i].wwa; wb_we = vt[i].wwe; wb_wd = vt[i].wwd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_A", i), A, vt[i].ea);
      chk($sformatf("vec%0d_B", i), B, vt[i].eb);
      chk($sformatf("vec%0d_ALUOp", i), 32'(ALUOp), 32'(vt[i].eop));
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_reg_write", i), 32'(ex_reg_write), 32'(vt[i].erw));
      chk($sformatf("vec%0d_pc", i), ex_pc, vt[i].epc);
      chk($sformatf("vec%0d_wa", i), 32'(ex_wa), 32'(vt[i].ewa));
      chk($sformatf("vec%0d_cnt", i), 32'(bubble_cnt), 32'(vt[i].ecnt));
    end

    // Hold refresh: rs=8 is forwarded from WB for one held cycle, then WB idles.
    stall = 1'b0; flush = 1'b0; id_valid = 1'b1; id_pc = 32'h200;
    id_rs = 5'd8; id_rs_data = 32'h1; id_rt = 5'd0; id_rt_data = 32'h0;
    id_alu_src = 1'b0; id_alu_op = 3'd0; id_wa = 5'd11; id_reg_write = 1'b1;
    idle_fwd();
    @(posedge clk); #1;
    chk("hold_pre_A", A, 32'h1);
    hold = 1'b1; wb_we = 1'b1; wb_wa = 5'd8; wb_wd = 32'h1234;
    id_pc = 32'h300; id_rs_data = 32'h55;
    #1;
    chk("hold_fwd_A", A, 32'h1234);
    @(posedge clk); #1;
    chk("hold_c1_A", A, 32'h1234);
    idle_fwd();
    #1;
    chk("hold_idle_A", A, 32'h1234);
    chk("hold_idle_pc", ex_pc, 32'h200);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_c%0d_A", k + 2), A, 32'h1234);
      chk($sformatf("hold_c%0d_pc", k + 2), ex_pc, 32'h200);
    end

    // Hold together with flush: the hold wins, nothing is bubbled or counted.
    flush = 1'b1;
    @(posedge clk); #1;
    chk("holdflush_valid", 32'(ex_valid), 32'h1);
    chk("holdflush_cnt", 32'(bubble_cnt), 32'd3);
    chk("holdflush_pc", ex_pc, 32'h200);
    flush = 1'b0;

    // Asynchronous reset mid-hold, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1; hold = 1'b0;

    // Randomized traffic against the model.
    m = '{default: 0};
    mcnt = 0;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      id_valid = 1'($urandom); id_pc = $urandom; id_rs_data = $urandom;
      id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_wa = 5'($urandom); id_alu_op = 3'($urandom_range(0, 4));
      id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
      mem_we = 1'($urandom); mem_wa = 5'($urandom_range(0, 7)); mem_wd = $urandom;
      wb_we = 1'($urandom); wb_wa = 5'($urandom_range(0, 7)); wb_wd = $urandom;
      #1;
      model_next();
      @(posedge clk);
      m = nm;
      mcnt = ncnt;
      #1;
      mem_we = 1'($urandom); mem_wa = 5'($urandom_range(0, 7)); mem_wd = $urandom;
      wb_we = 1'($urandom); wb_wa = 5'($urandom_range(0, 7)); wb_wd = $urandom;
      #1;
      check_model();
    end

    // Long stall run: the counter must stick at all-ones.
    stall = 1'b1; flush = 1'b0; hold = 1'b0;
    idle_fwd();
    repeat (65536) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(bubble_cnt), 32'h0000FFFF);
    @(posedge clk); #1;
    chk("sat_hold_cnt", 32'(bubble_cnt), 32'h0000FFFF);
    chk("sat_valid", 32'(ex_valid), 32'h0);
    stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core, directly upstream of the EX-stage ALU. It latches decoded operands and control from ID and resolves MEM/WB forwarding at its outputs, presenting final `A`, `B` and `ALUOp` to the ALU. It supports bubble insertion for stall and flush, a hold mode for EX back-pressure, and a saturating bubble counter.

## Interface
Parameters:
- `WIDTH`, 32: data path width.
- `CNT_W`, 16: bubble counter width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  load-use hazard from the hazard unit; inserts a bubble.
- `flush`  in  1  branch/exception flush; inserts a bubble.
- `hold`  in  1  EX busy; freezes the stage contents.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  32  PC of the ID instruction.
- `id_rs_data`, `id_rt_data`  in  WIDTH  register file read data.
- `id_imm`  in  WIDTH  extended immediate.
- `id_rs`, `id_rt`, `id_wa`  in  5  source and destination register numbers.
- `id_alu_op`  in  3  ALU operation code.
- `id_alu_src`  in  1  1 selects the immediate for B.
- `id_reg_write`  in  1  instruction writes `id_wa`.
- `mem_wa`, `wb_wa`  in  5  destinations in the MEM and WB stages.
- `mem_we`, `wb_we`  in  1  MEM and WB write enables.
- `mem_wd`, `wb_wd`  in  WIDTH  MEM and WB result data.
- `A`, `B`  out  WIDTH  ALU operands.
- `ALUOp`  out  3  ALU operation.
- `ex_rt_val`  out  WIDTH  forwarded rt value, used as store data.
- `ex_wa`  out  5  destination register.
- `ex_reg_write`  out  1  qualified write enable.
- `ex_pc`  out  32  PC of the EX instruction.
- `ex_valid`  out  1  EX holds a real instruction.
- `bubble_cnt`  out  CNT_W  number of bubbles inserted.

## Operation
- Registered state: valid, pc, rs_val, rt_val, imm, rs, rt, wa, alu_op, alu_src, reg_write.
- Update priority on each rising edge:
  1. `hold`: keep control fields, and overwrite rs_val and rt_val with their currently forwarded values. This refresh is required: the producer may retire from WB while EX is held.
  2. `flush` or `stall`: load a bubble. valid=0, reg_write=0, wa=0, alu_op=ADD, all data fields 0. `bubble_cnt` increments, saturating at all-ones.
  3. Otherwise: load all `id_*` fields.
- Forwarding is applied separately to the registered rs and to the registered rt, for register number r:
  - If r==0, use the registered value.
  - Else if `mem_we` and `mem_wa`==r, use `mem_wd`.
  - Else if `wb_we` and `wb_wa`==r, use `wb_wd`.
  - Else use the registered value.
  - MEM wins over WB.
- Output mapping:
  - `A` = forwarded rs.
  - `B` = alu_src ? imm : forwarded rt.
  - `ex_rt_val` = forwarded rt.
  - `ALUOp` = alu_op.
  - `ex_reg_write` = reg_write & valid.
- `hold` together with `flush`: hold wins. The flush is the requester's responsibility to reassert once hold drops.
- There is no wrap-around in `bubble_cnt`.

## Timing
- ID-to-EX latency is 1 cycle. Forwarding outputs are combinational from registered state and the MEM/WB inputs in the same cycle.
- Reset (async assert, sync release): all outputs 0, `ALUOp`=ADD (3'b000), `ex_valid`=0, `bubble_cnt`=0.
- Reset asserted mid-hold discards the held instruction.
- `stall` for N consecutive cycles produces N bubbles and N counts.
- `hold` for N cycles keeps `ex_pc` constant. `A` and `B` track the forwarded values throughout.

## Structure
- Shared package `mips_pkg` holds:
  - ALU op encodings (`ALU_ADD`=3'b000 … `ALU_OR`=3'b100), shared with the ALU;
  - `REG_ZERO`=5'd0;
  - the bubble field values.
- One sub-module, `fwd_mux`, is instantiated twice (rs and rt). Inputs: reg number, registered value, and the MEM/WB triples. Output: the selected value.

## Test plan
- Reset then load: `id_rs_data`=0x36, `id_rt_data`=0x1D, `id_alu_op`=3'b100, `id_alu_src`=0, no forwarding. One cycle later `A`=0x36, `B`=0x1D, `ALUOp`=4, `ex_valid`=1.
- Forward priority: rs=5; `mem_wa`=5, `mem_wd`=0xAAAA, `mem_we`=1; `wb_wa`=5, `wb_wd`=0xBBBB, `wb_we`=1. Expect `A`=0xAAAA. Drop `mem_we` and expect `A`=0xBBBB.
- Zero register: rt=0, `mem_wa`=0, `mem_we`=1, `mem_wd`=0xFFFF, `id_rt_data`=0. Expect `B`=0.
- Stall then flush: assert `stall` 2 cycles, then `flush` 1 cycle. Expect `ex_valid`=0 and `ex_reg_write`=0 in each of those cycles, and `bubble_cnt`=3.
- Hold refresh: EX holds rs=8 and WB forwards 0x1234 for one cycle while `hold`=1. Afterwards the WB inputs go idle and hold stays 2 more cycles. Expect `A`=0x1234 throughout and `ex_pc` unchanged.
- Async reset mid-hold: drop `rst_n` between clock edges. Expect all outputs to clear immediately with no clock edge, and `bubble_cnt`=0.
